prewish_mask_arbiter: RTL

PREWISH_MASK_ARBITER -- requirements
Module: prewish_mask_arbiter

---
 rtl/prewish_mask_arbiter_if.sv | 23 ++
 rtl/prewish_mask_arbiter.sv | 98 +++++++++
 2 files changed

// File: rtl/prewish_mask_arbiter_if.sv
// Handshake bundle between the requesters and the mask arbiter.
// The slave side is the arbiter; the master side drives requests and mask bytes.
interface prewish_mask_arbiter_if;
    logic        EN_I;
    logic [3:0]  REQ_I;
    logic [31:0] DAT_I;
    logic [3:0]  ACK_O;
    logic        STB_O;
    logic [7:0]  DAT_O;
    logic [1:0]  GNT_O;
    logic        BUSY_O;
    logic        o_alive;

    modport slave (
        input  EN_I, REQ_I, DAT_I,
        output ACK_O, STB_O, DAT_O, GNT_O, BUSY_O, o_alive
    );

    modport master (
        output EN_I, REQ_I, DAT_I,
        input  ACK_O, STB_O, DAT_O, GNT_O, BUSY_O, o_alive
    );
endinterface

// File: rtl/prewish_mask_arbiter.sv
// Round-robin arbiter for four mask-byte requesters. Each grant is followed by
// one load strobe and a programmable idle gap before the next grant.
module prewish_mask_arbiter #(
    parameter int unsigned GAP_CYCLES = 4
) (
    input  logic                   CLK_I,
    input  logic                   RST_I,
    prewish_mask_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, STROBE, GAP} state_t;

    state_t      state_q;
    logic [3:0]  ack_q;
    logic        stb_q;
    logic [7:0]  dat_q;
    logic [1:0]  gnt_q;
    logic [7:0]  cnt_q;
    logic        busy_q;
    logic        alive_q;

    logic [1:0]  gnt_d;
    logic        hit_d;
    logic [1:0]  cand;

    // Search starts one past the last winner; k=4 wraps back to the last winner.
    always_comb begin
        hit_d = 1'b0;
        gnt_d = gnt_q;
        cand  = gnt_q;
        for (int k = 1; k <= 4; k++) begin
            cand = gnt_q + 2'(k);
            if (!hit_d && bus.REQ_I[cand]) begin
                hit_d = 1'b1;
                gnt_d = cand;
            end
        end
    end

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            state_q <= IDLE;
            ack_q   <= 4'b0000;
            stb_q   <= 1'b0;
            dat_q   <= 8'h00;
            gnt_q   <= 2'd3;
            cnt_q   <= 8'd0;
            busy_q  <= 1'b0;
            alive_q <= 1'b1;
        end else begin
            ack_q <= 4'b0000;
            stb_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.EN_I && hit_d) begin
                        ack_q   <= 4'b0001 << gnt_d;
                        dat_q   <= bus.DAT_I[{gnt_d, 3'b000} +: 8];
                        gnt_q   <= gnt_d;
                        alive_q <= ~alive_q;
                        state_q <= STROBE;
                        busy_q  <= 1'b1;
                    end
                end
                STROBE: begin
                    stb_q <= 1'b1;
                    if (GAP_CYCLES == 0) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q   <= 8'(GAP_CYCLES);
                        state_q <= GAP;
                        busy_q  <= 1'b1;
                    end
                end
                GAP: begin
                    cnt_q <= cnt_q - 8'd1;
                    // Leave on the edge that takes the counter to zero.
                    if (cnt_q == 8'd1) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ACK_O   = ack_q;
    assign bus.STB_O   = stb_q;
    assign bus.DAT_O   = dat_q;
    assign bus.GNT_O   = gnt_q;
    assign bus.BUSY_O  = busy_q;
    assign bus.o_alive = alive_q;

endmodule
